// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command codes, arbiter one-hot states,
// address wrap limits and the read-back test pattern (used by read and write engines).
package sdram_pkg;

  typedef enum logic [3:0] {
    CMD_AREF = 4'b0001,
    CMD_PRE  = 4'b0010,
    CMD_ACT  = 4'b0011,
    CMD_WR   = 4'b0100,
    CMD_RD   = 4'b0101,
    CMD_NOP  = 4'b0111
  } sdram_cmd_e;

  localparam logic [5:0] ST_IDLE  = 6'b00_0001;
  localparam logic [5:0] ST_INIT  = 6'b00_0010;
  localparam logic [5:0] ST_ARB   = 6'b00_0100;
  localparam logic [5:0] ST_WRITE = 6'b00_1000;
  localparam logic [5:0] ST_READ  = 6'b01_0000;
  localparam logic [5:0] ST_AREF  = 6'b10_0000;

  localparam logic [8:0]  COL_END      = 9'd508;
  localparam logic [11:0] ROW_END      = 12'd4095;
  localparam logic [11:0] ADDR_PRE_ALL = 12'h400;

  function automatic logic [15:0] test_word(input logic [1:0] idx);
    case (idx)
      2'd0:    test_word = 16'h0012;
      2'd1:    test_word = 16'h1203;
      2'd2:    test_word = 16'h562f;
      default: test_word = 16'hfe12;
    endcase
  endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read data capture: samples DQ for four cycles CAS_LAT after the RD command, output
// registered one cycle later. Optional pattern checker under SDRAM_RD_CHECK_EN.
module sdram_rd_capture #(
  parameter int unsigned CAS_LAT = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_read,
  input  logic [3:0]  cmd_cnt,
  input  logic [15:0] dq_in,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
`ifdef SDRAM_RD_CHECK_EN
  ,
  output logic        rd_err
`endif
);

  localparam logic [3:0] WIN_LO = 4'(CAS_LAT + 4);
  localparam logic [3:0] WIN_HI = 4'(CAS_LAT + 7);

  logic        win;
  logic [15:0] rd_data_q, rd_data_d;
  logic        vld_q, vld_d;

  // Window is gated by the arbiter state so an aborted burst never shows valid data.
  assign win = in_read && (cmd_cnt >= WIN_LO) && (cmd_cnt <= WIN_HI);

  always_comb begin
    rd_data_d = win ? dq_in : rd_data_q;
    vld_d     = win;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data_q <= '0;
      vld_q     <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      vld_q     <= vld_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign rd_data_vld = vld_q;

`ifdef SDRAM_RD_CHECK_EN
  import sdram_pkg::*;

  logic [1:0] beat_q, beat_d;
  logic       err_q, err_d;

  always_comb begin
    beat_d = beat_q;
    err_d  = err_q;
    if (cmd_cnt == 4'd0) beat_d = 2'd0;
    else if (vld_q)      beat_d = beat_q + 2'd1;
    if (vld_q && (rd_data_q != test_word(beat_q))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_q <= 2'd0;
      err_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      err_q  <= err_d;
    end
  end

  assign rd_err = err_q;
`endif

endmodule

// File: rtl/sdram_read.sv
// SDRAM read burst engine: request bus, then PRE/ACT/RD (BL4) from a registered command
// counter; data valid 4 cycles, flag_rd_end pulse at the end. SDRAM_RD_CHECK_EN adds rd_err.
module sdram_read #(
  parameter int unsigned CAS_LAT = 3,
  parameter logic [8:0]  COL_END = sdram_pkg::COL_END,
  parameter logic [11:0] ROW_END = sdram_pkg::ROW_END,
  parameter logic [5:0]  READ_ST = sdram_pkg::ST_READ,
  parameter logic [5:0]  AREF_ST = sdram_pkg::ST_AREF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_rd,
  input  logic        rd_en,
  input  logic        ref_req,
  input  logic [5:0]  state,
  input  logic [15:0] sdram_dq_in,
  output logic [3:0]  sdram_cmd,
  output logic [11:0] sdram_addr,
  output logic [1:0]  sdram_bank,
  output logic [1:0]  sdram_dqm,
  output logic        rd_req,
  output logic        flag_rd_end,
  output logic [15:0] rd_data,
  output logic        rd_data_vld
`ifdef SDRAM_RD_CHECK_EN
  ,
  output logic        rd_err
`endif
);

  import sdram_pkg::*;

  localparam logic [3:0] CMD_END = 4'(CAS_LAT + 9);

  logic        in_read, burst_end, abort;
  logic [3:0]  cmd_cnt_q, cmd_cnt_d;
  sdram_cmd_e  cmd_q, cmd_d;
  logic [11:0] addr_q, addr_d;
  logic [11:0] row_q, row_d;
  logic [8:0]  col_q, col_d;
  logic        row_open_q, row_open_d;
  logic        need_act_q, need_act_d;
  logic        rd_req_q, rd_req_d;
  logic        flag_q, flag_d;
  logic        unused_ref_req;

  // Refresh is sequenced by the arbiter after flag_rd_end; a pending request never cuts a burst.
  assign unused_ref_req = ref_req;

  assign in_read   = (state == READ_ST);
  assign burst_end = (cmd_cnt_q == CMD_END);
  assign abort     = !in_read && (cmd_cnt_q != 4'd0) && (cmd_cnt_q < CMD_END);

  always_comb begin
    cmd_cnt_d  = 4'd0;
    cmd_d      = CMD_NOP;
    addr_d     = row_q;
    row_d      = row_q;
    col_d      = col_q;
    row_open_d = row_open_q;
    need_act_d = need_act_q;
    rd_req_d   = rd_req_q;
    flag_d     = burst_end;

    // Saturate so a lingering grant cannot replay the command sequence.
    if (in_read) cmd_cnt_d = (cmd_cnt_q == 4'hf) ? 4'hf : cmd_cnt_q + 4'd1;

    if (rd_en)                  rd_req_d = 1'b0;
    else if (key_rd && !in_read) rd_req_d = 1'b1;

    if (in_read) begin
      case (cmd_cnt_q)
        4'd1: if (row_open_q && need_act_q) begin
          cmd_d      = CMD_PRE;
          addr_d     = ADDR_PRE_ALL;
          row_open_d = 1'b0;
        end
        4'd2: if (need_act_q) begin
          cmd_d      = CMD_ACT;
          row_open_d = 1'b1;
          need_act_d = 1'b0;
        end
        4'd3: begin
          cmd_d  = CMD_RD;
          addr_d = {3'b000, col_q};
        end
        default: ;
      endcase
    end

    if (burst_end) begin
      if (col_q == COL_END) begin
        col_d      = 9'd0;
        row_d      = (row_q == ROW_END) ? 12'd0 : row_q + 12'd1;
        need_act_d = 1'b1;
      end else begin
        col_d = col_q + 9'd4;
      end
    end

    if (state == AREF_ST) begin
      row_open_d = 1'b0;
      need_act_d = 1'b1;
    end

    if (abort) need_act_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_cnt_q  <= 4'd0;
      cmd_q      <= CMD_NOP;
      addr_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      row_open_q <= 1'b0;
      need_act_q <= 1'b1;
      rd_req_q   <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      cmd_cnt_q  <= cmd_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      row_open_q <= row_open_d;
      need_act_q <= need_act_d;
      rd_req_q   <= rd_req_d;
      flag_q     <= flag_d;
    end
  end

  assign sdram_cmd   = cmd_q;
  assign sdram_addr  = addr_q;
  assign sdram_bank  = 2'b00;
  assign sdram_dqm   = 2'b00;
  assign rd_req      = rd_req_q;
  assign flag_rd_end = flag_q;

  sdram_rd_capture #(.CAS_LAT(CAS_LAT)) u_capture (
    .clk         (clk),
    .rstn        (rstn),
    .in_read     (in_read),
    .cmd_cnt     (cmd_cnt_q),
    .dq_in       (sdram_dq_in),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld)
`ifdef SDRAM_RD_CHECK_EN
    ,
    .rd_err      (rd_err)
`endif
  );

endmodule

// File: tb/tb_sdram_read.sv
// Scoreboard bench for sdram_read with small address limits so row change and wrap are reachable.
`timescale 1ns/1ps
module tb_sdram_read;
  import sdram_pkg::*;

  localparam int CL = 3;

  logic        clk = 1'b0, rstn = 1'b1;
  logic        key_rd = 1'b0, rd_en = 1'b0, ref_req = 1'b0;
  logic [5:0]  state = ST_IDLE;
  logic [15:0] dq = 16'h0;
  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank, sdram_dqm;
  logic        rd_req, flag_rd_end, rd_data_vld;
  logic [15:0] rd_data;
`ifdef SDRAM_RD_CHECK_EN
  logic        rd_err;
`endif

  sdram_read #(.CAS_LAT(CL), .COL_END(9'd8), .ROW_END(12'd2)) dut (
    .clk(clk), .rstn(rstn), .key_rd(key_rd), .rd_en(rd_en), .ref_req(ref_req),
    .state(state), .sdram_dq_in(dq), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
    .sdram_bank(sdram_bank), .sdram_dqm(sdram_dqm), .rd_req(rd_req),
    .flag_rd_end(flag_rd_end), .rd_data(rd_data), .rd_data_vld(rd_data_vld)
`ifdef SDRAM_RD_CHECK_EN
    , .rd_err(rd_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] cmd; logic [11:0] addr; } cmd_t;
  cmd_t        cmd_sb[$];
  logic [15:0] dat_sb[$];
  logic [15:0] words[4];
  int total = 0, bad = 0, cyc = 0, age = -1, last_rd = -100, beats = 0, flags = 0;
  logic exp_err = 1'b0, prev_vld = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SDRAM model, command scoreboard and data scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      age = -1;
      dq  = 16'h0;
      prev_vld = 1'b0;
    end else begin
      if (sdram_cmd != CMD_NOP) begin
        if (cmd_sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_cmd: got %0h/%0h expected none", sdram_cmd, sdram_addr);
        end else begin
          cmd_t e;
          e = cmd_sb.pop_front();
          chk("cmd", 32'(sdram_cmd), 32'(e.cmd));
          chk("addr", 32'(sdram_addr), 32'(e.addr));
          chk("bank_dqm", 32'({sdram_bank, sdram_dqm}), 32'd0);
        end
        if (sdram_cmd == CMD_RD) last_rd = cyc;
      end
      if (sdram_cmd == CMD_RD) age = 0;
      else if (age >= 0) age++;
      dq = (age >= CL && age < CL + 4) ? words[age-CL] : 16'h0;

      if (flag_rd_end) begin
        flags++;
        chk("flag_time", 32'(cyc), 32'(last_rd + CL + 6));
      end
`ifdef SDRAM_RD_CHECK_EN
      if (prev_vld) chk("rd_err", 32'(rd_err), 32'(exp_err));
`endif
      prev_vld = rd_data_vld;
      if (rd_data_vld) begin
        if (dat_sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_vld: got %0h expected none", rd_data);
        end else begin
          logic [15:0] w;
          w = dat_sb.pop_front();
          chk("rd_data", 32'(rd_data), 32'(w));
          chk("vld_time", 32'(cyc), 32'(last_rd + CL + 1 + (beats % 4)));
          if (w != test_word(2'(beats % 4))) exp_err = 1'b1;
          beats++;
        end
      end
    end
  end

  task automatic tick; @(posedge clk); #1; endtask
  task automatic exp_cmd(input logic [3:0] c, input logic [11:0] a); cmd_sb.push_back(cmd_t'({c, a})); endtask
  task automatic exp_data; for (int i = 0; i < 4; i++) dat_sb.push_back(words[i]); endtask

  task automatic request_grant;
    key_rd = 1'b1; tick; key_rd = 1'b0;
    chk("rd_req_set", 32'(rd_req), 32'd1);
    rd_en = 1'b1; state = ST_READ; tick; rd_en = 1'b0;
    chk("rd_req_clr", 32'(rd_req), 32'd0);
  endtask

  task automatic finish_burst;
    int n;
    n = 0;
    while (!flag_rd_end && n < 40) begin tick; n++; end
    if (!flag_rd_end) begin
      total++; bad++;
      $display("FAIL flag_timeout: got no flag_rd_end expected one within 40 cycles");
    end
    state = ST_IDLE; tick;
    chk("flag_width", 32'(flag_rd_end), 32'd0);
  endtask

  task automatic burst; request_grant; finish_burst; endtask

  task automatic check_reset_outputs;
    chk("rst_cmd", 32'(sdram_cmd), 32'(CMD_NOP));
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_flags", 32'({rd_req, flag_rd_end, rd_data_vld}), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
  endtask

  initial begin
    int f0;
    for (int i = 0; i < 4; i++) words[i] = test_word(2'(i));
    #2 rstn = 1'b0;
    repeat (3) tick;
    check_reset_outputs;
    chk("rst_bank_dqm", 32'({sdram_bank, sdram_dqm}), 32'd0);
    rstn = 1'b1; tick;

    exp_cmd(CMD_ACT, 12'd0); exp_cmd(CMD_RD, 12'd0); exp_data; burst;
    // Same row; key_rd during READ is ignored and ref_req does not cut the burst.
    exp_cmd(CMD_RD, 12'd4); exp_data; ref_req = 1'b1;
    request_grant; tick; key_rd = 1'b1; tick; key_rd = 1'b0;
    chk("key_rd_ignored", 32'(rd_req), 32'd0);
    finish_burst; ref_req = 1'b0;
    exp_cmd(CMD_RD, 12'd8); exp_data; burst;
    exp_cmd(CMD_PRE, 12'h400); exp_cmd(CMD_ACT, 12'd1); exp_cmd(CMD_RD, 12'd0); exp_data; burst;

    state = ST_AREF; repeat (3) tick; state = ST_IDLE; tick;
    exp_cmd(CMD_ACT, 12'd1); exp_cmd(CMD_RD, 12'd4); exp_data; burst;
    exp_cmd(CMD_RD, 12'd8); exp_data; burst;
    exp_cmd(CMD_PRE, 12'h400); exp_cmd(CMD_ACT, 12'd2); exp_cmd(CMD_RD, 12'd0); exp_data; burst;
    exp_cmd(CMD_RD, 12'd4); exp_data; burst;
    exp_cmd(CMD_RD, 12'd8); exp_data; burst;
    exp_cmd(CMD_PRE, 12'h400); exp_cmd(CMD_ACT, 12'd0); exp_cmd(CMD_RD, 12'd0); exp_data; burst;

    key_rd = 1'b1; tick; key_rd = 1'b0;
    chk("rd_req_pre", 32'(rd_req), 32'd1);
    key_rd = 1'b1; rd_en = 1'b1; tick; key_rd = 1'b0; rd_en = 1'b0;
    chk("rd_en_wins", 32'(rd_req), 32'd0);

    // Arbiter drops READ at cmd_cnt 5: no data, no flag, no address advance.
    exp_cmd(CMD_RD, 12'd4); f0 = flags;
    request_grant; repeat (4) tick; state = ST_IDLE; tick;
    repeat (10) tick;
    chk("abort_no_flag", 32'(flags), 32'(f0));
    exp_cmd(CMD_PRE, 12'h400); exp_cmd(CMD_ACT, 12'd0); exp_cmd(CMD_RD, 12'd4); exp_data; burst;

    // Reset asserted at cmd_cnt 6.
    exp_cmd(CMD_RD, 12'd8);
    request_grant; repeat (5) tick;
    rstn = 1'b0; #1;
    check_reset_outputs;
    exp_err = 1'b0; state = ST_IDLE;
    repeat (3) tick; rstn = 1'b1; tick;
    exp_cmd(CMD_ACT, 12'd0); exp_cmd(CMD_RD, 12'd0); exp_data; burst;

    words[2] = 16'h562e;
    exp_cmd(CMD_RD, 12'd4); exp_data; burst;
    words[2] = test_word(2'd2);
    repeat (5) tick;
`ifdef SDRAM_RD_CHECK_EN
    chk("rd_err_sticky", 32'(rd_err), 32'd1);
`endif
    chk("cmd_sb_empty", 32'(cmd_sb.size()), 32'd0);
    chk("dat_sb_empty", 32'(dat_sb.size()), 32'd0);
    chk("flag_count", 32'(flags), 32'd13);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1);
  end

endmodule
